// File: rtl/doom58_pkg.sv
// Shared grid geometry, cell codes and enemy_mover state encoding.
package doom58_pkg;
  localparam int GRID_W   = 64;
  localparam int GRID_H   = 32;
  localparam int XW       = 6;
  localparam int YW       = 5;
  localparam int FP_SHIFT = 8;

  localparam logic [2:0] CELL_EMPTY       = 3'd0;
  localparam logic [2:0] CELL_WALL        = 3'd1;
  localparam logic [2:0] CELL_ENEMY       = 3'd4;
  localparam logic [2:0] CELL_ENEMY_MOVED = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE, ST_S_ADDR, ST_S_WAIT, ST_S_CHECK,
    ST_T_ADDR, ST_T_WAIT, ST_T_CHECK, ST_W_TGT, ST_W_SRC,
    ST_F_ADDR, ST_F_WAIT, ST_F_CHECK, ST_F_WRITE, ST_DONE
  } mover_state_t;
endpackage

// File: rtl/enemy_step_dir.sv
// Picks the one-cell step of an enemy toward the player: the axis with the
// larger distance wins, ties go to X. Purely combinational.
module enemy_step_dir
  import doom58_pkg::*;
(
  input  logic [XW-1:0] ex,
  input  logic [YW-1:0] ey,
  input  logic [XW-1:0] pcx,
  input  logic [YW-1:0] pcy,
  output logic [XW-1:0] tx,
  output logic [YW-1:0] ty,
  output logic          at_player
);
  logic signed [XW:0] w_dx;
  logic signed [YW:0] w_dy;
  logic        [XW:0] w_adx;
  logic        [YW:0] w_ady;

  always_comb begin
    w_dx  = $signed({1'b0, pcx}) - $signed({1'b0, ex});
    w_dy  = $signed({1'b0, pcy}) - $signed({1'b0, ey});
    w_adx = w_dx[XW] ? 7'(-w_dx) : 7'(w_dx);
    w_ady = w_dy[YW] ? 6'(-w_dy) : 6'(w_dy);
    tx    = ex;
    ty    = ey;
    if (w_adx >= {1'b0, w_ady}) begin
      if (w_dx[XW])        tx = ex - XW'(1);
      else if (w_dx != '0) tx = ex + XW'(1);
    end else begin
      if (w_dy[YW])        ty = ey - YW'(1);
      else if (w_dy != '0) ty = ey + YW'(1);
    end
    at_player = (ex == pcx) && (ey == pcy);
  end
endmodule

// File: rtl/enemy_mover.sv
// Scans the level grid on each start, steps enemies toward the player every
// MOVE_PERIOD starts, then reports enemy count / player contact and pulses done.
module enemy_mover
  import doom58_pkg::*;
#(
  parameter int MOVE_PERIOD = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  output logic          done,
  input  logic [13:0]   player_x,
  input  logic [12:0]   player_y,
  output logic [XW-1:0] grid_x,
  output logic [YW-1:0] grid_y,
  input  logic [2:0]    grid_out,
  output logic          grid_write,
  output logic [2:0]    grid_in,
  output logic [11:0]   enemy_count,
  output logic          player_hit
);
  localparam int PW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(MOVE_PERIOD - 1);

  mover_state_t  r_state, w_state_nxt;
  logic [XW-1:0] r_grid_x, r_sx, r_pcx, w_gx_nxt, w_sx_nxt, w_tx, w_nx;
  logic [YW-1:0] r_grid_y, r_sy, r_pcy, w_gy_nxt, w_sy_nxt, w_ty, w_ny;
  logic [PW-1:0] r_period;
  logic [11:0]   r_cnt, w_cnt_nxt, r_enemy_count;
  logic          r_move, r_hit, w_hit_nxt, w_at_player, w_accept;
  logic          w_last, w_adv, w_fadv;
  logic          w_unused_frac;

  assign w_unused_frac = ^{player_x[FP_SHIFT-1:0], player_y[FP_SHIFT-1:0]};

  enemy_step_dir u_step (
    .ex(r_sx), .ey(r_sy), .pcx(r_pcx), .pcy(r_pcy),
    .tx(w_tx), .ty(w_ty), .at_player(w_at_player)
  );

  assign w_accept = start && (r_state == ST_IDLE);
  assign w_last   = (r_sx == XW'(GRID_W - 1)) && (r_sy == YW'(GRID_H - 1));
  assign w_nx     = r_sx + XW'(1);
  assign w_ny     = (r_sx == XW'(GRID_W - 1)) ? r_sy + YW'(1) : r_sy;

  always_comb begin
    w_state_nxt = r_state;
    w_gx_nxt    = r_grid_x;
    w_gy_nxt    = r_grid_y;
    w_sx_nxt    = r_sx;
    w_sy_nxt    = r_sy;
    w_cnt_nxt   = r_cnt;
    w_hit_nxt   = r_hit;
    w_adv       = 1'b0;
    w_fadv      = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_S_ADDR;
        {w_gx_nxt, w_gy_nxt, w_sx_nxt, w_sy_nxt} = '0;
        w_cnt_nxt   = '0;
        w_hit_nxt   = 1'b0;
      end
      ST_S_ADDR: w_state_nxt = ST_S_WAIT;
      ST_S_WAIT: w_state_nxt = ST_S_CHECK;
      ST_S_CHECK: begin
        w_adv = 1'b1;
        if (grid_out == CELL_ENEMY) begin
          w_cnt_nxt = r_cnt + 12'd1;
          if (w_at_player) begin
            w_hit_nxt = 1'b1;
          end else if (r_move) begin
            w_adv       = 1'b0;
            w_state_nxt = ST_T_ADDR;
            w_gx_nxt    = w_tx;
            w_gy_nxt    = w_ty;
          end
        end
      end
      ST_T_ADDR: w_state_nxt = ST_T_WAIT;
      ST_T_WAIT: w_state_nxt = ST_T_CHECK;
      ST_T_CHECK: begin
        if (r_grid_x == r_pcx && r_grid_y == r_pcy) begin
          w_hit_nxt = 1'b1;
          w_adv     = 1'b1;
        end else if (grid_out == CELL_EMPTY) begin
          w_state_nxt = ST_W_TGT;
        end else begin
          w_adv = 1'b1;
        end
      end
      ST_W_TGT: begin
        w_state_nxt = ST_W_SRC;
        w_gx_nxt    = r_sx;
        w_gy_nxt    = r_sy;
      end
      ST_W_SRC:   w_adv = 1'b1;
      ST_F_ADDR:  w_state_nxt = ST_F_WAIT;
      ST_F_WAIT:  w_state_nxt = ST_F_CHECK;
      ST_F_CHECK: if (grid_out == CELL_ENEMY_MOVED) w_state_nxt = ST_F_WRITE;
                  else w_fadv = 1'b1;
      ST_F_WRITE: w_fadv = 1'b1;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase

    // Step to the next cell of whichever pass is running.
    if (w_adv || w_fadv) begin
      if (!w_last) begin
        w_state_nxt = w_adv ? ST_S_ADDR : ST_F_ADDR;
        w_sx_nxt    = w_nx;
        w_sy_nxt    = w_ny;
        w_gx_nxt    = w_nx;
        w_gy_nxt    = w_ny;
      end else if (w_adv && r_move) begin
        w_state_nxt = ST_F_ADDR;
        {w_gx_nxt, w_gy_nxt, w_sx_nxt, w_sy_nxt} = '0;
      end else begin
        w_state_nxt = ST_DONE;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_grid_x      <= '0;
      r_grid_y      <= '0;
      r_sx          <= '0;
      r_sy          <= '0;
      r_pcx         <= '0;
      r_pcy         <= '0;
      r_period      <= '0;
      r_move        <= 1'b0;
      r_cnt         <= '0;
      r_hit         <= 1'b0;
      r_enemy_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grid_x <= w_gx_nxt;
      r_grid_y <= w_gy_nxt;
      r_sx     <= w_sx_nxt;
      r_sy     <= w_sy_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hit    <= w_hit_nxt;
      if (w_accept) begin
        r_pcx    <= player_x[FP_SHIFT +: XW];
        r_pcy    <= player_y[FP_SHIFT +: YW];
        r_move   <= (r_period == P_LAST);
        r_period <= (r_period == P_LAST) ? '0 : r_period + PW'(1);
      end
      if (w_state_nxt == ST_DONE) r_enemy_count <= w_cnt_nxt;
    end
  end

  assign done        = (r_state == ST_DONE);
  assign grid_write  = (r_state == ST_W_TGT) || (r_state == ST_W_SRC) || (r_state == ST_F_WRITE);
  assign grid_in     = (r_state == ST_W_TGT)   ? CELL_ENEMY_MOVED :
                       (r_state == ST_F_WRITE) ? CELL_ENEMY : CELL_EMPTY;
  assign grid_x      = r_grid_x;
  assign grid_y      = r_grid_y;
  assign enemy_count = r_enemy_count;
  assign player_hit  = r_hit;
endmodule

// File: tb/tb_enemy_mover.sv
// Two movers (MOVE_PERIOD 1 and 4) each on its own modelled grid, run in parallel.
module tb_enemy_mover;
  import doom58_pkg::*;

  typedef struct packed {logic [11:0] cnt; logic hit;} res_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic        resetn1 = 1'b0, start1 = 1'b0, done1, gw1, hit1;
  logic [13:0] px1 = '0;
  logic [12:0] py1 = '0;
  logic [5:0]  gx1;
  logic [4:0]  gy1;
  logic [2:0]  gout1 = '0, gin1;
  logic [11:0] ec1;
  logic [2:0]  mem1 [0:2047];
  res_t        exp1[$], obs1[$];
  int          wr1 = 0, dn1 = 0;

  logic        resetn4 = 1'b0, start4 = 1'b0, done4, gw4, hit4;
  logic [13:0] px4 = '0;
  logic [12:0] py4 = '0;
  logic [5:0]  gx4;
  logic [4:0]  gy4;
  logic [2:0]  gout4 = '0, gin4;
  logic [11:0] ec4;
  logic [2:0]  mem4 [0:2047];
  res_t        exp4[$], obs4[$];
  int          wr4 = 0, dn4 = 0;

  enemy_mover #(.MOVE_PERIOD(1)) u_dut1 (
    .clock(clock), .resetn(resetn1), .start(start1), .done(done1),
    .player_x(px1), .player_y(py1), .grid_x(gx1), .grid_y(gy1),
    .grid_out(gout1), .grid_write(gw1), .grid_in(gin1),
    .enemy_count(ec1), .player_hit(hit1)
  );

  enemy_mover #(.MOVE_PERIOD(4)) u_dut4 (
    .clock(clock), .resetn(resetn4), .start(start4), .done(done4),
    .player_x(px4), .player_y(py4), .grid_x(gx4), .grid_y(gy4),
    .grid_out(gout4), .grid_write(gw4), .grid_in(gin4),
    .enemy_count(ec4), .player_hit(hit4)
  );

  // Grid RAM models: one-cycle registered read, write on the strobe edge.
  always @(posedge clock) begin
    gout1 <= mem1[{gy1, gx1}];
    if (gw1) begin mem1[{gy1, gx1}] = gin1; wr1++; end
    gout4 <= mem4[{gy4, gx4}];
    if (gw4) begin mem4[{gy4, gx4}] = gin4; wr4++; end
  end

  always @(negedge clock) begin
    if (done1) begin dn1++; obs1.push_back({ec1, hit1}); end
    if (done4) begin dn4++; obs4.push_back({ec4, hit4}); end
  end

  function automatic int idx(input int x, input int y);
    return y * GRID_W + x;
  endfunction

  function automatic int moved_left1();
    int n = 0;
    for (int i = 0; i < 2048; i++) if (mem1[i] == CELL_ENEMY_MOVED) n++;
    return n;
  endfunction

  function automatic int moved_left4();
    int n = 0;
    for (int i = 0; i < 2048; i++) if (mem4[i] == CELL_ENEMY_MOVED) n++;
    return n;
  endfunction

  task automatic clear1();
    for (int i = 0; i < 2048; i++) mem1[i] = CELL_EMPTY;
  endtask

  task automatic clear4();
    for (int i = 0; i < 2048; i++) mem4[i] = CELL_EMPTY;
  endtask

  task automatic fire1(input logic [13:0] px, input logic [12:0] py);
    int n0 = dn1;
    @(negedge clock); px1 = px; py1 = py; start1 = 1'b1;
    @(negedge clock); start1 = 1'b0; px1 = '1; py1 = '1;
    for (int i = 0; i < 20000 && dn1 == n0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    total++;
    if (dn1 - n0 != 1) begin
      bad++;
      $display("FAIL dut1_done_pulses: got %0d expected 1", dn1 - n0);
    end
  endtask

  task automatic fire4(input logic [13:0] px, input logic [12:0] py, input bit busy_pulse);
    int n0 = dn4;
    @(negedge clock); px4 = px; py4 = py; start4 = 1'b1;
    @(negedge clock); start4 = 1'b0; px4 = '1; py4 = '1;
    if (busy_pulse) begin
      repeat (50) @(negedge clock);
      start4 = 1'b1; @(negedge clock); start4 = 1'b0;
    end
    for (int i = 0; i < 20000 && dn4 == n0; i++) @(negedge clock);
    repeat (20) @(negedge clock);
    total++;
    if (dn4 - n0 != 1) begin
      bad++;
      $display("FAIL dut4_done_pulses: got %0d expected 1", dn4 - n0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if ({done1, gw1, hit1, gx1, gy1, gin1, ec1} !== '0) begin
      bad++;
      $display("FAIL reset_dut1: done=%b wr=%b hit=%b x=%0d y=%0d in=%0d cnt=%0d expected all 0",
               done1, gw1, hit1, gx1, gy1, gin1, ec1);
    end
    total++;
    if ({done4, gw4, hit4, gx4, gy4, gin4, ec4} !== '0) begin
      bad++;
      $display("FAIL reset_dut4: done=%b wr=%b hit=%b x=%0d y=%0d in=%0d cnt=%0d expected all 0",
               done4, gw4, hit4, gx4, gy4, gin4, ec4);
    end
    resetn1 = 1'b1;
    resetn4 = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_empty1();
    int w0;
    res_t e, o;
    clear1();
    w0 = wr1;
    exp1.push_back('{cnt: 12'd0, hit: 1'b0});
    fire1(14'h0180, 13'h0180);
    total++;
    if (wr1 != w0) begin bad++; $display("FAIL empty_writes: got %0d expected 0", wr1 - w0); end
    e = exp1.pop_front();
    o = (obs1.size() > 0) ? obs1.pop_front() : 'x;
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL empty_result: got cnt=%0d hit=%b expected cnt=%0d hit=%b", o.cnt, o.hit, e.cnt, e.hit);
    end
  endtask

  task automatic test_move1();
    int w0;
    res_t e, o;
    clear1();
    mem1[idx(5, 1)] = CELL_ENEMY;
    w0 = wr1;
    exp1.push_back('{cnt: 12'd1, hit: 1'b0});
    fire1(14'h0180, 13'h0180);
    total++;
    if (mem1[idx(4, 1)] !== CELL_ENEMY || mem1[idx(5, 1)] !== CELL_EMPTY) begin
      bad++;
      $display("FAIL move_cells: (4,1)=%0d (5,1)=%0d expected 4 and 0", mem1[idx(4, 1)], mem1[idx(5, 1)]);
    end
    total++;
    if (moved_left1() != 0 || wr1 - w0 != 3) begin
      bad++;
      $display("FAIL move_fixup: moved_left=%0d writes=%0d expected 0 and 3", moved_left1(), wr1 - w0);
    end
    e = exp1.pop_front();
    o = (obs1.size() > 0) ? obs1.pop_front() : 'x;
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL move_result: got cnt=%0d hit=%b expected cnt=%0d hit=%b", o.cnt, o.hit, e.cnt, e.hit);
    end
  endtask

  task automatic test_wall1();
    int w0;
    res_t e, o;
    clear1();
    mem1[idx(3, 1)] = CELL_ENEMY;
    mem1[idx(2, 1)] = CELL_WALL;
    w0 = wr1;
    exp1.push_back('{cnt: 12'd1, hit: 1'b0});
    fire1(14'h0180, 13'h0180);
    total++;
    if (mem1[idx(3, 1)] !== CELL_ENEMY || mem1[idx(2, 1)] !== CELL_WALL || wr1 != w0) begin
      bad++;
      $display("FAIL wall_blocked: (3,1)=%0d (2,1)=%0d writes=%0d expected 4 1 0",
               mem1[idx(3, 1)], mem1[idx(2, 1)], wr1 - w0);
    end
    e = exp1.pop_front();
    o = (obs1.size() > 0) ? obs1.pop_front() : 'x;
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL wall_result: got cnt=%0d hit=%b expected cnt=%0d hit=%b", o.cnt, o.hit, e.cnt, e.hit);
    end
  endtask

  task automatic test_hit1();
    res_t e, o;
    clear1();
    mem1[idx(2, 1)] = CELL_ENEMY;
    exp1.push_back('{cnt: 12'd1, hit: 1'b1});
    fire1(14'h0180, 13'h0180);
    total++;
    if (mem1[idx(2, 1)] !== CELL_ENEMY || mem1[idx(1, 1)] !== CELL_EMPTY) begin
      bad++;
      $display("FAIL hit_stays: (2,1)=%0d (1,1)=%0d expected 4 and 0", mem1[idx(2, 1)], mem1[idx(1, 1)]);
    end
    e = exp1.pop_front();
    o = (obs1.size() > 0) ? obs1.pop_front() : 'x;
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL hit_result: got cnt=%0d hit=%b expected cnt=%0d hit=%b", o.cnt, o.hit, e.cnt, e.hit);
    end
  endtask

  // Player below the enemy, so the moved enemy lands ahead in scan order.
  task automatic test_period4();
    int w0;
    res_t e, o;
    clear4();
    mem4[idx(10, 10)] = CELL_ENEMY;
    for (int k = 1; k <= 4; k++) begin
      w0 = wr4;
      exp4.push_back('{cnt: 12'd1, hit: 1'b0});
      fire4(14'h0A80, 13'h0E80, k == 1);
      total++;
      if (k < 4 && (wr4 != w0 || mem4[idx(10, 10)] !== CELL_ENEMY)) begin
        bad++;
        $display("FAIL period_idle_start%0d: writes=%0d (10,10)=%0d expected 0 and 4", k, wr4 - w0, mem4[idx(10, 10)]);
      end else if (k == 4 && (wr4 - w0 != 3 || mem4[idx(10, 10)] !== CELL_EMPTY ||
                              mem4[idx(10, 11)] !== CELL_ENEMY || mem4[idx(10, 12)] !== CELL_EMPTY ||
                              moved_left4() != 0)) begin
        bad++;
        $display("FAIL period_move: writes=%0d (10,10)=%0d (10,11)=%0d (10,12)=%0d moved_left=%0d expected 3 0 4 0 0",
                 wr4 - w0, mem4[idx(10, 10)], mem4[idx(10, 11)], mem4[idx(10, 12)], moved_left4());
      end
      e = exp4.pop_front();
      o = (obs4.size() > 0) ? obs4.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL period_result%0d: got cnt=%0d hit=%b expected cnt=%0d hit=%b", k, o.cnt, o.hit, e.cnt, e.hit);
      end
    end
  endtask

  task automatic test_reset_mid4();
    int n0, w0;
    res_t e, o;
    n0 = dn4;
    @(negedge clock); px4 = 14'h0A80; py4 = 13'h0E80; start4 = 1'b1;
    @(negedge clock); start4 = 1'b0;
    repeat (500) @(negedge clock);
    resetn4 = 1'b0;
    #1;
    total++;
    if ({done4, gw4, hit4, gx4, gy4, gin4, ec4} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: done=%b wr=%b hit=%b x=%0d y=%0d in=%0d cnt=%0d expected all 0",
               done4, gw4, hit4, gx4, gy4, gin4, ec4);
    end
    repeat (3) @(negedge clock);
    resetn4 = 1'b1;
    repeat (20) @(negedge clock);
    total++;
    if (dn4 != n0) begin bad++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dn4 - n0); end
    w0 = wr4;
    exp4.push_back('{cnt: 12'd1, hit: 1'b0});
    fire4(14'h0A80, 13'h0E80, 1'b0);
    total++;
    if (wr4 != w0 || mem4[idx(10, 11)] !== CELL_ENEMY) begin
      bad++;
      $display("FAIL midreset_rerun_grid: writes=%0d (10,11)=%0d expected 0 and 4", wr4 - w0, mem4[idx(10, 11)]);
    end
    e = exp4.pop_front();
    o = (obs4.size() > 0) ? obs4.pop_front() : 'x;
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL midreset_rerun_result: got cnt=%0d hit=%b expected cnt=%0d hit=%b", o.cnt, o.hit, e.cnt, e.hit);
    end
  endtask

  initial begin
    clear1();
    clear4();
    test_reset();
    fork
      begin
        test_empty1();
        test_move1();
        test_wall1();
        test_hit1();
      end
      begin
        test_period4();
        test_reset_mid4();
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
